uart_tx_fifo: RTL

UART_TX_FIFO -- requirements
Module: uart_tx_fifo

---
 rtl/uart_tx_fifo.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: byte FIFO that feeds a UART transmitter one frame at a time.
// Host writes bytes in; a three-state drain FSM pops the head into o_Tx_Byte,
// pulses o_Tx_Ready for one cycle, then waits for i_Tx_Done before the next pop.
// Optional feature macro: UART_TX_FIFO_OVF_STICKY_EN enables a sticky overflow
// flag on dropped writes; without it o_Overflow is tied low.
module uart_tx_fifo #(
  parameter int unsigned DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     i_Wr_En,
  input  logic [7:0]               i_Wr_Byte,
  output logic                     o_Full,
  output logic                     o_Empty,
  output logic [$clog2(DEPTH):0]   o_Count,
  output logic [7:0]               o_Tx_Byte,
  output logic                     o_Tx_Ready,
  input  logic                     i_Tx_Done,
  output logic                     o_Overflow,
  input  logic                     i_Ovf_Clr
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  if ((DEPTH < 2) || (DEPTH > 256) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_depth_check
    $error("uart_tx_fifo: DEPTH must be a power of two in 2..256");
  end

  typedef enum logic [1:0] {StIdle, StLaunch, StBusy} state_e;

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;
  state_e        state_q;
  logic [7:0]    tx_byte_q;
  logic          tx_ready_q;
  logic          wr_accept;
  logic          pop;

  assign o_Full     = (count_q == CW'(DEPTH));
  assign o_Empty    = (count_q == '0);
  assign o_Count    = count_q;
  assign o_Tx_Byte  = tx_byte_q;
  assign o_Tx_Ready = tx_ready_q;

  // A full FIFO drops the write even when a pop frees a slot on the same edge.
  assign wr_accept = i_Wr_En && !o_Full;

  // The head leaves the FIFO whenever the transmitter side is free to take it.
  assign pop = (count_q != '0) &&
               ((state_q == StIdle) || ((state_q == StBusy) && i_Tx_Done));

  // Occupancy next-state: simultaneous write and pop leave it unchanged.
  always_comb begin
    count_d = count_q;
    case ({wr_accept, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Storage array; contents are not reset, only the pointers are.
  always_ff @(posedge clk) begin
    if (wr_accept) begin
      mem_q[wr_ptr_q] <= i_Wr_Byte;
    end
  end

  // Pointers and occupancy; power-of-two depth lets the pointers wrap naturally.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (wr_accept) begin
        wr_ptr_q <= wr_ptr_q + AW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      count_q <= count_d;
    end
  end

  // Drain FSM with registered byte and launch pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      tx_byte_q  <= 8'h00;
      tx_ready_q <= 1'b0;
    end else begin
      tx_ready_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (pop) begin
            tx_byte_q  <= mem_q[rd_ptr_q];
            tx_ready_q <= 1'b1;
            state_q    <= StLaunch;
          end
        end
        StLaunch: begin
          state_q <= StBusy;
        end
        StBusy: begin
          if (i_Tx_Done) begin
            if (pop) begin
              tx_byte_q  <= mem_q[rd_ptr_q];
              tx_ready_q <= 1'b1;
              state_q    <= StLaunch;
            end else begin
              state_q <= StIdle;
            end
          end
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

`ifdef UART_TX_FIFO_OVF_STICKY_EN
  logic ovf_q;

  // Sticky overflow: a drop wins over a clear on the same edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ovf_q <= 1'b0;
    end else if (i_Wr_En && o_Full) begin
      ovf_q <= 1'b1;
    end else if (i_Ovf_Clr) begin
      ovf_q <= 1'b0;
    end
  end

  assign o_Overflow = ovf_q;
`else
  logic unused_ovf_clr;

  assign unused_ovf_clr = i_Ovf_Clr;
  assign o_Overflow     = 1'b0;
`endif

endmodule
